ext_mem_ctrl: RTL and testbench

Bridges the processor core's external memory port (`addr`, `data_in`, `data_out`, `omem_wr`, `omem_re`, `mem_ready`) to a single-port synchronous SRAM. It latches each core request, drives the SRAM for one access cycle and inserts a programmable number of wait states. It then returns read data with a one-cycle `mem_ready` pulse. It sits directly downstream of the core; the core holds its request stable while stalled on `mem_ready`.

---
 rtl/ext_mem_ctrl_pkg.sv | 30 +++
 rtl/ext_mem_ctrl_if.sv | 42 ++++
 rtl/ext_mem_ctrl_wait_counter.sv | 40 ++++
 rtl/ext_mem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ext_mem_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ext_mem_ctrl_pkg
//  Description : Shared types and constants for the external memory
//                controller. Holds the FSM state encoding, the default
//                wait-state count and the address range helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ext_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int unsigned c_wait_cycles_default = 0;
    localparam int unsigned c_cnt_w               = 4;

    // True when every byte-address bit above the SRAM word range is zero.
    // Written as a shift so it remains legal when the SRAM covers the whole
    // 32-bit space (the shift amount then reaches 32 and yields 0).
    function automatic logic addr_in_range(input logic [31:0] a,
                                           input int unsigned aw);
        return ((a >> (aw + 2)) == 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ext_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ext_mem_ctrl_if
//  Description : Bus bundle between the core memory port, the controller and
//                the SRAM.
//                slave  : the controller (takes core requests, drives SRAM)
//                master : the environment (core side plus SRAM read data)
//  Signals     : addr, data_in, mem_wr, mem_re    core request
//                data_out, mem_ready, err         core response
//                sram_en, sram_we, sram_addr,
//                sram_wdata, sram_rdata           SRAM port
//  Revision    : 1.0 - initial release
// ============================================================================
interface ext_mem_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic [31:0]       addr;
    logic [31:0]       data_in;
    logic              mem_wr;
    logic              mem_re;
    logic [31:0]       data_out;
    logic              mem_ready;
    logic              err;
    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    modport slave (
        input  addr, data_in, mem_wr, mem_re, sram_rdata,
        output data_out, mem_ready, err,
               sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output addr, data_in, mem_wr, mem_re, sram_rdata,
        input  data_out, mem_ready, err,
               sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/ext_mem_ctrl_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ext_mem_ctrl_wait_counter
//  Description : Loadable down-counter with a zero flag. Stops at zero.
//  Ports       : clk, rst      clock / synchronous active-high reset
//                i_load        load i_load_val (has priority over i_dec)
//                i_load_val    value to load
//                i_dec         decrement when non-zero
//                o_zero        count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_mem_ctrl_wait_counter
    import ext_mem_ctrl_pkg::*;
#(
    parameter int WIDTH = c_cnt_w
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ext_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ext_mem_ctrl
//  Description : Bridges the core external memory port to a single-port
//                synchronous SRAM (1-cycle read latency). Each request is
//                latched in IDLE, drives the SRAM for one ACCESS cycle, waits
//                1+WAIT_CYCLES cycles and completes with a one-cycle
//                mem_ready pulse in RESP.
//  Ports       : clk           clock, rising edge
//                rst           synchronous active-high reset
//                bus (slave)   core request/response and SRAM port
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_mem_ctrl
    import ext_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int WAIT_CYCLES = c_wait_cycles_default
) (
    input  logic          clk,
    input  logic          rst,
    ext_mem_ctrl_if.slave bus
);

    localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'(WAIT_CYCLES);

    state_t r_state;
    state_t w_state_next;

    logic w_req;
    logic w_misaligned;
    logic w_out_of_range;
    logic w_latch;
    logic w_wait_done;
    logic w_cnt_load;
    logic w_cnt_dec;
    logic w_cnt_zero;

    // Attributes of the request captured in IDLE
    logic r_op_wr;
    logic r_oor;
    logic r_err;

    // Registered outputs
    logic [31:0]       r_data_out;
    logic              r_mem_ready;
    logic              r_err_out;
    logic              r_sram_en;
    logic              r_sram_we;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [31:0]       r_sram_wdata;

    assign w_req          = bus.mem_re | bus.mem_wr;
    assign w_misaligned   = (bus.addr[1:0] != 2'b00);
    assign w_out_of_range = !addr_in_range(bus.addr, ADDR_W);

    // The counter is loaded on the ACCESS cycle so that the first WAIT cycle
    // already sees WAIT_CYCLES; WAIT therefore lasts WAIT_CYCLES+1 cycles.
    assign w_cnt_load = (r_state == ST_ACCESS);
    assign w_cnt_dec  = (r_state == ST_WAIT);

    ext_mem_ctrl_wait_counter #(
        .WIDTH (c_cnt_w)
    ) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (c_wait_load),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_wait_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_cnt_zero) begin
                    w_wait_done  = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. SRAM strobes are registered on the latch edge so they are
    // high exactly during ACCESS; the response is registered on the WAIT
    // exit edge so it is high exactly during RESP.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_wr      <= 1'b0;
            r_oor        <= 1'b0;
            r_err        <= 1'b0;
            r_data_out   <= '0;
            r_mem_ready  <= 1'b0;
            r_err_out    <= 1'b0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
        end else begin
            r_sram_en   <= 1'b0;
            r_mem_ready <= 1'b0;
            r_err_out   <= 1'b0;

            if (w_latch) begin
                // A simultaneous read+write is performed as a write.
                r_op_wr      <= bus.mem_wr;
                r_oor        <= w_out_of_range;
                r_err        <= (bus.mem_wr & bus.mem_re) | w_misaligned
                                | w_out_of_range;
                r_sram_en    <= !w_out_of_range;
                r_sram_we    <= bus.mem_wr;
                r_sram_addr  <= bus.addr[ADDR_W+1:2];
                r_sram_wdata <= bus.data_in;
            end

            if (w_wait_done) begin
                r_mem_ready <= 1'b1;
                r_err_out   <= r_err;
                // data_out only changes on reads; writes leave the last
                // read value visible.
                if (!r_op_wr) begin
                    r_data_out <= r_oor ? 32'd0 : bus.sram_rdata;
                end
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.mem_ready  = r_mem_ready;
    assign bus.err        = r_err_out;
    assign bus.sram_en    = r_sram_en;
    assign bus.sram_we    = r_sram_we;
    assign bus.sram_addr  = r_sram_addr;
    assign bus.sram_wdata = r_sram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ext_mem_ctrl
//  Description : Directed self-checking bench. Three controllers share the
//                core-side address/data stimulus: WAIT_CYCLES = 0, 3 and 5,
//                each with its own behavioural SRAM (1-cycle read latency)
//                and its own request strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_mem_ctrl;

    localparam int AW = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]   addr    = '0;
    logic [31:0]   data_in = '0;
    logic [2:0]    re_v    = '0;
    logic [2:0]    wr_v    = '0;
    logic [2:0]    pl_en   = '0;
    logic [AW-1:0] pl_addr = '0;
    logic [31:0]   pl_data = '0;

    logic [2:0]          ready_v, err_v, en_v, we_v;
    logic [2:0][31:0]    dout_v, wdata_v;
    logic [2:0][AW-1:0]  saddr_v;

    int n_pass  = 0;
    int n_total = 0;

    // Results of the most recent request
    int            res_lat;
    int            res_en;
    logic [AW-1:0] res_saddr;
    logic          res_we;
    logic [31:0]   res_wdata;
    logic [31:0]   res_dout;
    logic          res_err;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int WC = (g == 0) ? 0 : ((g == 1) ? 3 : 5);

            ext_mem_ctrl_if #(.ADDR_W(AW)) bus ();

            logic [31:0] mem [0:(1<<AW)-1];
            logic [31:0] rdata = '0;

            ext_mem_ctrl #(
                .ADDR_W      (AW),
                .WAIT_CYCLES (WC)
            ) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );

            assign bus.addr       = addr;
            assign bus.data_in    = data_in;
            assign bus.mem_re     = re_v[g];
            assign bus.mem_wr     = wr_v[g];
            assign bus.sram_rdata = rdata;

            assign ready_v[g] = bus.mem_ready;
            assign err_v[g]   = bus.err;
            assign en_v[g]    = bus.sram_en;
            assign we_v[g]    = bus.sram_we;
            assign dout_v[g]  = bus.data_out;
            assign wdata_v[g] = bus.sram_wdata;
            assign saddr_v[g] = bus.sram_addr;

            // Behavioural synchronous SRAM with a backdoor preload port.
            always @(posedge clk) begin
                if (pl_en[g]) begin
                    mem[pl_addr] <= pl_data;
                end else if (bus.sram_en) begin
                    if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
                    else             rdata <= mem[bus.sram_addr];
                end
            end
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic preload(input int d, input logic [AW-1:0] a,
                           input logic [31:0] v);
        @(negedge clk);
        pl_addr  = a;
        pl_data  = v;
        pl_en[d] = 1'b1;
        @(negedge clk);
        pl_en = '0;
    endtask

    // Presents a request to controller d and holds it until mem_ready.
    // res_lat is the cycle of mem_ready counted from the IDLE cycle that
    // first sees the request (-1 if it never arrives within the bound).
    task automatic req(input int d, input logic wr, input logic re,
                       input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        addr    = a;
        data_in = wd;
        wr_v[d] = wr;
        re_v[d] = re;
        res_lat = -1;
        res_en  = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (en_v[d]) begin
                res_en++;
                res_saddr = saddr_v[d];
                res_we    = we_v[d];
                res_wdata = wdata_v[d];
            end
            if (ready_v[d]) begin
                res_lat  = k;
                res_dout = dout_v[d];
                res_err  = err_v[d];
                break;
            end
        end
        wr_v[d] = 1'b0;
        re_v[d] = 1'b0;
    endtask

    initial begin
        int p1;
        int p2;
        int pulses;

        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mem_ready", 32'(ready_v), 32'd0);
        chk("rst_err",       32'(err_v),   32'd0);
        chk("rst_sram_en",   32'(en_v),    32'd0);
        chk("rst_data_out0", dout_v[0],    32'd0);
        chk("rst_data_out1", dout_v[1],    32'd0);
        chk("rst_sram_addr", 32'(saddr_v[0]) | 32'(saddr_v[1]) | 32'(saddr_v[2]), 32'd0);
        rst = 1'b0;

        preload(0, 14'd5, 32'hDEAD_BEEF);
        preload(1, 14'd7, 32'hCAFE_F00D);
        preload(2, 14'd9, 32'h0BAD_F00D);

        // ---------------- WAIT_CYCLES = 0 ----------------
        req(0, 1'b0, 1'b1, 32'h0000_0014, 32'd0);
        chk("aligned_lat",   32'(res_lat),   32'd3);
        chk("aligned_en",    32'(res_en),    32'd1);
        chk("aligned_saddr", 32'(res_saddr), 32'd5);
        chk("aligned_we",    32'(res_we),    32'd0);
        chk("aligned_dout",  res_dout,       32'hDEAD_BEEF);
        chk("aligned_err",   32'(res_err),   32'd0);

        req(0, 1'b0, 1'b1, 32'h0000_0015, 32'd0);
        chk("misalign_lat",   32'(res_lat),   32'd3);
        chk("misalign_saddr", 32'(res_saddr), 32'd5);
        chk("misalign_dout",  res_dout,       32'hDEAD_BEEF);
        chk("misalign_err",   32'(res_err),   32'd1);

        req(0, 1'b0, 1'b1, 32'h0001_0000, 32'd0);
        chk("oor_lat",  32'(res_lat), 32'd3);
        chk("oor_en",   32'(res_en),  32'd0);
        chk("oor_dout", res_dout,     32'd0);
        chk("oor_err",  32'(res_err), 32'd1);

        req(0, 1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5);
        chk("rw_lat",   32'(res_lat),   32'd3);
        chk("rw_we",    32'(res_we),    32'd1);
        chk("rw_saddr", 32'(res_saddr), 32'd2);
        chk("rw_wdata", res_wdata,      32'hA5A5_A5A5);
        chk("rw_err",   32'(res_err),   32'd1);
        chk("rw_dout",  res_dout,       32'd0);

        req(0, 1'b0, 1'b1, 32'h0000_0008, 32'd0);
        chk("rw_readback_dout", res_dout,     32'hA5A5_A5A5);
        chk("rw_readback_err",  32'(res_err), 32'd0);

        // Request held continuously: pulses every 4 cycles, IDLE between.
        @(negedge clk);
        addr    = 32'h0000_0014;
        re_v[0] = 1'b1;
        p1 = -1;
        p2 = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ready_v[0]) begin
                if (p1 < 0)      p1 = k;
                else if (p2 < 0) p2 = k;
            end
        end
        re_v[0] = 1'b0;
        chk("b2b_first",  32'(p1), 32'd3);
        chk("b2b_second", 32'(p2), 32'd7);
        repeat (6) @(negedge clk);

        // ---------------- WAIT_CYCLES = 3 ----------------
        req(1, 1'b0, 1'b1, 32'h0000_001C, 32'd0);
        chk("ws3_read0_lat",  32'(res_lat), 32'd6);
        chk("ws3_read0_dout", res_dout,     32'hCAFE_F00D);

        req(1, 1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678);
        chk("ws3_write_lat",   32'(res_lat),   32'd6);
        chk("ws3_write_saddr", 32'(res_saddr), 32'd16);
        chk("ws3_write_we",    32'(res_we),    32'd1);
        chk("ws3_write_err",   32'(res_err),   32'd0);
        chk("ws3_write_dout",  res_dout,       32'hCAFE_F00D);

        req(1, 1'b0, 1'b1, 32'h0000_0040, 32'd0);
        chk("ws3_read_lat",  32'(res_lat), 32'd6);
        chk("ws3_read_dout", res_dout,     32'h1234_5678);
        chk("ws3_read_err",  32'(res_err), 32'd0);

        // ---------------- WAIT_CYCLES = 5, reset during WAIT ----------------
        @(negedge clk);
        addr    = 32'h0000_0024;
        re_v[2] = 1'b1;
        repeat (3) @(negedge clk);   // now in the second WAIT cycle
        rst     = 1'b1;
        re_v[2] = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(ready_v[2]), 32'd0);
        chk("midrst_en",    32'(en_v[2]),    32'd0);
        chk("midrst_err",   32'(err_v[2]),   32'd0);
        chk("midrst_dout",  dout_v[2],       32'd0);
        chk("midrst_saddr", 32'(saddr_v[2]), 32'd0);
        chk("midrst_wdata", wdata_v[2],      32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ready_v[2]) pulses++;
        end
        chk("midrst_no_pulse", 32'(pulses), 32'd0);

        req(2, 1'b0, 1'b1, 32'h0000_0024, 32'd0);
        chk("postrst_lat",  32'(res_lat), 32'd8);
        chk("postrst_dout", res_dout,     32'h0BAD_F00D);
        chk("postrst_err",  32'(res_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
